// File: rtl/pmod_ad1_pkg.sv
// Shared types and AD7476A frame constants for the PmodAD1 sampler.
package pmod_ad1_pkg;
  typedef enum logic [2:0] {IDLE, CS_SETUP, SHIFT, CS_HOLD, QUIET} state_e;

  localparam int AD7476_FRAME_BITS = 16;
  localparam int AD7476_DATA_W     = 12;
endpackage

// File: rtl/pmod_ad1_sampler_spi_tick_gen.sv
// SPI half-period tick generator: one-cycle tick every DIV clocks.
// A restart re-phases the divider so the first tick lands DIV+1 cycles later.
module spi_tick_gen #(
  parameter int DIV = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] cnt_reg;
  logic             tick_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg  <= '0;
      tick_reg <= 1'b0;
    end else if (restart) begin
      cnt_reg  <= '0;
      tick_reg <= 1'b0;
    end else begin
      tick_reg <= (cnt_reg == CNT_W'(DIV - 1));
      cnt_reg  <= (cnt_reg == CNT_W'(DIV - 1)) ? '0 : cnt_reg + 1'b1;
    end
  end

  assign tick = tick_reg;
endmodule

// File: rtl/pmod_ad1_sampler.sv
// Multi-channel PmodAD1 (AD7476A) sampler: shared ~CS/SCLK, parallel capture,
// single-shot or timer-paced frames, results delivered on a valid/ready stream.
module pmod_ad1_sampler
  import pmod_ad1_pkg::*;
#(
  parameter int CLK_FREQ   = 125_000_000,
  parameter int SPI_FREQ   = 12_500_000,
  parameter int NUM_CH     = 2,
  parameter int FRAME_BITS = AD7476_FRAME_BITS,
  parameter int DATA_W     = AD7476_DATA_W,
  parameter int SAMPLE_DIV = 2500,
  parameter int QUIET_CYC  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic                     ad_cs_n,
  output logic                     ad_sclk,
  input  logic [NUM_CH-1:0]        ad_d,
  input  logic                     enable,
  input  logic                     mode,
  input  logic                     start_conv,
  output logic                     busy,
  output logic [NUM_CH*DATA_W-1:0] sample_data,
  output logic                     sample_valid,
  input  logic                     sample_ready,
  output logic [NUM_CH-1:0]        frame_err,
  output logic                     overrun,
  input  logic                     clr_overrun
);
  localparam int CLK_DIV = CLK_FREQ / (2 * SPI_FREQ);
  localparam int BIT_W   = $clog2(FRAME_BITS + 1);
  localparam int TMR_W   = $clog2(SAMPLE_DIV);
  localparam int QW      = $clog2(QUIET_CYC + 1);

  state_e              state_reg;
  logic [BIT_W-1:0]    bit_cnt_reg;
  logic [QW-1:0]       quiet_cnt_reg;
  logic [TMR_W-1:0]    timer_reg;
  logic                cs_n_reg, sclk_reg, busy_reg, cont_reg;
  logic                valid_reg, overrun_reg;
  logic [NUM_CH*DATA_W-1:0] data_reg;
  logic [NUM_CH-1:0]   err_reg;
  logic [FRAME_BITS-1:0] ch_frame [NUM_CH];

  logic tick, timer_tc, launch, shift_en, frame_load;

  assign timer_tc   = (timer_reg == TMR_W'(SAMPLE_DIV - 1));
  assign launch     = (state_reg == IDLE) && enable && (mode ? timer_tc : start_conv);
  assign shift_en   = (state_reg == SHIFT) && tick && !sclk_reg;
  assign frame_load = (state_reg == CS_HOLD) && tick;

  spi_tick_gen #(.DIV(CLK_DIV)) u_tick (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (launch),
    .tick    (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      bit_cnt_reg   <= '0;
      quiet_cnt_reg <= '0;
      cs_n_reg      <= 1'b1;
      sclk_reg      <= 1'b0;
      busy_reg      <= 1'b0;
      cont_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: if (launch) begin
          state_reg   <= CS_SETUP;
          busy_reg    <= 1'b1;
          cont_reg    <= mode;
          bit_cnt_reg <= '0;
        end
        CS_SETUP: begin
          cs_n_reg <= 1'b0;
          if (tick) state_reg <= SHIFT;
        end
        SHIFT: if (tick) begin
          if (!sclk_reg) begin
            sclk_reg    <= 1'b1;
            bit_cnt_reg <= bit_cnt_reg + 1'b1;
          end else begin
            sclk_reg <= 1'b0;
            if (bit_cnt_reg == BIT_W'(FRAME_BITS)) state_reg <= CS_HOLD;
          end
        end
        CS_HOLD: if (tick) begin
          cs_n_reg      <= 1'b1;
          quiet_cnt_reg <= '0;
          state_reg     <= QUIET;
        end
        QUIET: begin
          if (quiet_cnt_reg == QW'(QUIET_CYC - 1)) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end else begin
            quiet_cnt_reg <= quiet_cnt_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Pacing timer free-runs while enabled; launches only happen from IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             timer_reg <= '0;
    else if (!enable)       timer_reg <= '0;
    else if (timer_tc)      timer_reg <= '0;
    else                    timer_reg <= timer_reg + 1'b1;
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [FRAME_BITS-1:0] shift_reg;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        shift_reg <= '0;
      else if (shift_en) shift_reg <= {shift_reg[FRAME_BITS-2:0], ad_d[gi]};
    end
    assign ch_frame[gi] = shift_reg;
  end

  // A completed frame always replaces the word; overrun flags a lost one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_reg    <= '0;
      err_reg     <= '0;
      valid_reg   <= 1'b0;
      overrun_reg <= 1'b0;
    end else begin
      if (frame_load) begin
        for (int n = 0; n < NUM_CH; n++) begin
          data_reg[n*DATA_W +: DATA_W] <= ch_frame[n][DATA_W-1:0];
          err_reg[n] <= |ch_frame[n][FRAME_BITS-1:DATA_W];
        end
        valid_reg <= 1'b1;
      end else if (valid_reg && sample_ready) begin
        valid_reg <= 1'b0;
      end
      overrun_reg <= (frame_load && valid_reg && !sample_ready) ||
                     (overrun_reg && !clr_overrun);
    end
  end

  a_no_tc_while_busy: assert property (@(posedge clk) disable iff (!rst_n)
    !(timer_tc && busy_reg && cont_reg));

  assign ad_cs_n      = cs_n_reg;
  assign ad_sclk      = sclk_reg;
  assign busy         = busy_reg;
  assign sample_data  = data_reg;
  assign frame_err    = err_reg;
  assign sample_valid = valid_reg;
  assign overrun      = overrun_reg;
endmodule

// File: tb/tb_pmod_ad1_sampler.sv
// Self-checking bench for pmod_ad1_sampler with an AD7476A model per channel.
module tb_pmod_ad1_sampler;
  localparam int LATENCY = 172;
  localparam int NV      = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ad_cs_n, ad_sclk;
  logic [1:0]  ad_d;
  logic        enable = 1'b0, mode = 1'b0, start_conv = 1'b0;
  logic        busy;
  logic [23:0] sample_data;
  logic        sample_valid;
  logic        sample_ready = 1'b1;
  logic [1:0]  frame_err;
  logic        overrun;
  logic        clr_overrun = 1'b0;

  always #5 clk = ~clk;

  pmod_ad1_sampler #(
    .CLK_FREQ(125_000_000), .SPI_FREQ(12_500_000), .NUM_CH(2), .FRAME_BITS(16),
    .DATA_W(12), .SAMPLE_DIV(2500), .QUIET_CYC(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ad_cs_n(ad_cs_n), .ad_sclk(ad_sclk), .ad_d(ad_d),
    .enable(enable), .mode(mode), .start_conv(start_conv), .busy(busy),
    .sample_data(sample_data), .sample_valid(sample_valid), .sample_ready(sample_ready),
    .frame_err(frame_err), .overrun(overrun), .clr_overrun(clr_overrun)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", nm, act);
    end
  endtask

  // AD7476A model: first bit on ~CS fall, next bit after each SCLK fall.
  logic [15:0] mw [2];
  int   nfall = 16;
  logic cs_q = 1'b1, sclk_q = 1'b0;
  always @(posedge clk) begin
    cs_q   <= ad_cs_n;
    sclk_q <= ad_sclk;
    if (cs_q && !ad_cs_n)                      nfall <= 0;
    else if (!ad_cs_n && sclk_q && !ad_sclk)   nfall <= nfall + 1;
  end
  always_comb begin
    for (int n = 0; n < 2; n++) ad_d[n] = (nfall < 16) ? mw[n][15-nfall] : 1'b0;
  end

  typedef struct packed { logic [23:0] data; logic [1:0] err; } exp_t;
  exp_t sb_q[$];
  exp_t mon_e;
  int   cyc = 0, rise_cnt = 0, cs_low_cnt = 0;
  logic cs_prev = 1'b1, sclk_prev = 1'b0;
  int   cs_fall_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!ad_cs_n && cs_prev) begin
      cs_low_cnt = 0;
      rise_cnt   = 0;
      cs_fall_q.push_back(cyc);
    end
    if (!ad_cs_n) cs_low_cnt++;
    if (ad_sclk && !sclk_prev) rise_cnt++;
    cs_prev   = ad_cs_n;
    sclk_prev = ad_sclk;
    if (sample_valid && sample_ready) begin
      if (sb_q.size() == 0) begin
        check("sb_word_expected", 32'd0, 32'd1);
      end else begin
        mon_e = sb_q.pop_front();
        check("sb_data", 32'(sample_data), 32'(mon_e.data));
        check("sb_err",  32'(frame_err),   32'(mon_e.err));
      end
    end
  end

  task automatic wait_valid(input string nm, input int bound);
    int n = 0;
    while (!sample_valid && n < bound) begin @(negedge clk); n++; end
    if (!sample_valid) check({nm, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic run_single(output int lat);
    start_conv = 1'b1;
    @(negedge clk);
    start_conv = 1'b0;
    lat = 1;
    while (!sample_valid && lat < 400) begin @(negedge clk); lat++; end
    if (!sample_valid) check("single_valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_frame_end(input string nm);
    int n = 0;
    while (ad_cs_n && n < 3000) begin @(negedge clk); n++; end
    if (ad_cs_n) check({nm, "_cs_fall_timeout"}, 32'd0, 32'd1);
    n = 0;
    while (!ad_cs_n && n < 400) begin @(negedge clk); n++; end
    if (!ad_cs_n) check({nm, "_cs_rise_timeout"}, 32'd0, 32'd1);
  endtask

  typedef struct { logic [15:0] w0; logic [15:0] w1; logic [23:0] data; logic [1:0] err; } vec_t;
  vec_t vecs [NV];

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lat, nf, bad;
    exp_t e;
    vecs[0] = '{16'h0ABC, 16'h0123, 24'h123ABC, 2'b00};
    vecs[1] = '{16'h0555, 16'h8FFF, 24'hFFF555, 2'b10};
    vecs[2] = '{16'hF000, 16'h0000, 24'h000000, 2'b01};
    vecs[3] = '{16'h0FFF, 16'h0800, 24'h800FFF, 2'b00};
    vecs[4] = '{16'h1001, 16'h4002, 24'h002001, 2'b11};
    mw[0] = 16'h0; mw[1] = 16'h0;

    repeat (3) @(negedge clk);
    check("rst_cs_n", 32'(ad_cs_n), 32'd1);
    check("rst_sclk", 32'(ad_sclk), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(sample_valid), 32'd0);
    check("rst_data", 32'(sample_data), 32'd0);
    check("rst_err", 32'(frame_err), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    rst_n = 1'b1; enable = 1'b1; mode = 1'b0;
    @(negedge clk);

    // Single-shot table
    for (int i = 0; i < NV; i++) begin
      mw[0] = vecs[i].w0; mw[1] = vecs[i].w1;
      e.data = vecs[i].data; e.err = vecs[i].err;
      sb_q.push_back(e);
      run_single(lat);
      check($sformatf("v%0d_latency", i), 32'(lat), 32'(LATENCY));
      check($sformatf("v%0d_sclk_rises", i), 32'(rise_cnt), 32'd16);
      check($sformatf("v%0d_cs_low_cycles", i), 32'(cs_low_cnt), 32'd170);
      repeat (20) @(negedge clk);
    end

    // Continuous ramp with ready held high
    cs_fall_q.delete();
    for (int k = 0; k < 10; k++) begin
      mw[0] = 16'(k); mw[1] = 16'(k + 'h100);
      e.data = {12'(k + 'h100), 12'(k)}; e.err = 2'b00;
      sb_q.push_back(e);
      if (k == 0) mode = 1'b1;
      wait_valid($sformatf("t2_frame%0d", k), 3000);
      @(negedge clk);
    end
    check("t2_cs_falls", 32'(cs_fall_q.size()), 32'd10);
    for (int i = 1; i < cs_fall_q.size(); i++)
      check($sformatf("t2_period%0d", i), 32'(cs_fall_q[i] - cs_fall_q[i-1]), 32'd2500);
    check("t2_overrun", 32'(overrun), 32'd0);

    // Continuous with ready low: overwrite and sticky overrun
    sample_ready = 1'b0;
    mw[0] = 16'h0111; mw[1] = 16'h0222;
    wait_frame_end("t3_f1");
    check("t3_f1_valid", 32'(sample_valid), 32'd1);
    check("t3_f1_overrun", 32'(overrun), 32'd0);
    mw[0] = 16'h0333; mw[1] = 16'h0444;
    wait_frame_end("t3_f2");
    check("t3_f2_overrun", 32'(overrun), 32'd1);
    mw[0] = 16'h0555; mw[1] = 16'h0666;
    wait_frame_end("t3_f3");
    enable = 1'b0;
    check("t3_f3_data", 32'(sample_data), 32'h666555);
    check("t3_f3_overrun", 32'(overrun), 32'd1);
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (sample_data !== 24'h666555 || sample_valid !== 1'b1) bad = 1;
    end
    check("t3_hold_stable", 32'(bad), 32'd0);
    clr_overrun = 1'b1;
    @(negedge clk);
    clr_overrun = 1'b0;
    check("t3_clr", 32'(overrun), 32'd0);
    mode = 1'b0; enable = 1'b1;
    mw[0] = 16'h0777; mw[1] = 16'h0888;
    start_conv = 1'b1;
    @(negedge clk);
    start_conv = 1'b0;
    repeat (170) @(negedge clk);
    clr_overrun = 1'b1;
    @(negedge clk);
    clr_overrun = 1'b0;
    check("t3_set_wins", 32'(overrun), 32'd1);
    check("t3_overwrite_data", 32'(sample_data), 32'h888777);
    e.data = 24'h888777; e.err = 2'b00;
    sb_q.push_back(e);
    sample_ready = 1'b1;
    repeat (20) @(negedge clk);

    // Asynchronous reset in the middle of a frame
    mw[0] = 16'h0999; mw[1] = 16'h0AAA;
    start_conv = 1'b1;
    @(negedge clk);
    start_conv = 1'b0;
    repeat (72) @(negedge clk);
    check("t5_rise_count", 32'(rise_cnt), 32'd7);
    #2 rst_n = 1'b0;
    #1;
    check("t5_cs_n", 32'(ad_cs_n), 32'd1);
    check("t5_sclk", 32'(ad_sclk), 32'd0);
    check("t5_valid", 32'(sample_valid), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_overrun", 32'(overrun), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mw[0] = 16'h0ACE; mw[1] = 16'h0BDF;
    e.data = 24'hBDFACE; e.err = 2'b00;
    sb_q.push_back(e);
    run_single(lat);
    check("t5_clean_latency", 32'(lat), 32'(LATENCY));
    repeat (20) @(negedge clk);

    // enable dropped mid-frame in continuous mode
    mode = 1'b1; enable = 1'b1;
    mw[0] = 16'h0321; mw[1] = 16'h0654;
    e.data = 24'h654321; e.err = 2'b00;
    sb_q.push_back(e);
    nf = 0;
    while (ad_cs_n && nf < 3000) begin @(negedge clk); nf++; end
    check("t6_cs_fell", 32'(ad_cs_n), 32'd0);
    repeat (40) @(negedge clk);
    enable = 1'b0;
    wait_valid("t6_valid", 400);
    nf = cs_fall_q.size();
    repeat (3000) @(negedge clk);
    check("t6_no_relaunch", 32'(cs_fall_q.size()), 32'(nf));

    // start_conv while busy is ignored
    mode = 1'b0; enable = 1'b1;
    mw[0] = 16'h0010; mw[1] = 16'h0020;
    e.data = 24'h020010; e.err = 2'b00;
    sb_q.push_back(e);
    start_conv = 1'b1;
    @(negedge clk);
    start_conv = 1'b0;
    repeat (50) @(negedge clk);
    check("t6_busy_mid", 32'(busy), 32'd1);
    start_conv = 1'b1;
    @(negedge clk);
    start_conv = 1'b0;
    wait_valid("t6_single_valid", 400);
    nf = cs_fall_q.size();
    repeat (400) @(negedge clk);
    check("t6_busy_start_ignored", 32'(cs_fall_q.size()), 32'(nf));
    check("t6_idle_busy", 32'(busy), 32'd0);

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
